// File: rtl/arb3_rr_if.sv
`timescale 1ps/1ps
// arb3_rr_if: request/grant bundle between requesters and the arb3_rr arbiter.
// Latency: none, this is wiring only.
// Backpressure: none here; the owner holds the resource by keeping its req bit high.
// Signals: en, req[2:0] (requester side to arbiter);
//          gnt[2:0], busy, last[1:0], tmo (arbiter to requester side).
interface arb3_rr_if;
  logic       en;
  logic [2:0] req;
  logic [2:0] gnt;
  logic       busy;
  logic [1:0] last;
  logic       tmo;

  modport master (output en, req, input gnt, busy, last, tmo);
  modport slave  (input en, req, output gnt, busy, last, tmo);
endinterface

// File: rtl/arb3_rr.sv
`timescale 1ps/1ps
// arb3_rr: three-requester round-robin arbiter with a registered one-hot grant and a hold timeout.
// Latency: gnt rises 1 cycle after the request is sampled; on release or timeout gnt falls at the next
//          edge and is followed by one GAP cycle.
// Backpressure: the owner keeps the resource while its req stays high, for at most TIMEOUT cycles;
//               en gates new grants only.
// Ports: ck, nrst (async active-low reset);
//        bus (slave): en, req[2:0] in; gnt[2:0], busy, last[1:0], tmo out.
module arb3_rr #(
  parameter int TIMEOUT = 15,
  parameter int CW      = 4
) (
  input  logic     ck,
  input  logic     nrst,
  arb3_rr_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state_q;
  logic [2:0]    gnt_q;
  logic          busy_q;
  logic [1:0]    last_q;
  logic          tmo_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    owner_q;

  logic [1:0]    p0;
  logic [1:0]    p1;
  logic [1:0]    win_d;
  logic [2:0]    win_gnt_d;

  // Modulo-3 increment; last_q never holds 3.
  function automatic logic [1:0] inc3(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Circular search last+1, last+2, last. When neither of the first two is
  // requesting, the winner can only be last itself (a grant is only taken
  // when some req bit is high).
  always_comb begin
    p0    = inc3(last_q);
    p1    = inc3(p0);
    win_d = last_q;
    if (bus.req[p0]) begin
      win_d = p0;
    end else if (bus.req[p1]) begin
      win_d = p1;
    end
    win_gnt_d = 3'b001 << win_d;
  end

  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      gnt_q   <= 3'b000;
      busy_q  <= 1'b0;
      last_q  <= 2'd2;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
      owner_q <= 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          tmo_q <= 1'b0;
          if (bus.en && (bus.req != 3'b000)) begin
            gnt_q   <= win_gnt_d;
            busy_q  <= 1'b1;
            owner_q <= win_d;
            cnt_q   <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          // Release wins over timeout when both land on the same edge.
          if (!bus.req[owner_q]) begin
            gnt_q   <= 3'b000;
            busy_q  <= 1'b0;
            last_q  <= owner_q;
            state_q <= GAP;
          end else if (cnt_q == CNT_LAST) begin
            gnt_q   <= 3'b000;
            busy_q  <= 1'b0;
            last_q  <= owner_q;
            tmo_q   <= 1'b1;
            state_q <= GAP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        GAP: begin
          tmo_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          gnt_q   <= 3'b000;
          busy_q  <= 1'b0;
          tmo_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.busy = busy_q;
  assign bus.last = last_q;
  assign bus.tmo  = tmo_q;

endmodule
